// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART FIFO bridge:
//   UART_DEPTH_LOG2 - default log2 of the FIFO entry count (16 entries)
//   tx_state_e      - TX handshake FSM states (idle / one-cycle hold)
//   rx_state_e      - RX handshake FSM states (idle / one-cycle acknowledge)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DEPTH_LOG2 = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with 2^DEPTH_LOG2 entries.
// A push is accepted only when the FIFO is not full at the clock edge (a
// push into a full FIFO is dropped even if a pop happens in the same cycle);
// a pop of an empty FIFO is ignored.
// Ports:
//   clk    - clock, rising edge
//   resetb - asynchronous active-low reset (pointers and count only)
//   push   - write din
//   pop    - discard the head entry
//   din    - write data
//   dout   - head entry (show-ahead, don't-care when empty)
//   count  - occupancy, 0 .. 2^DEPTH_LOG2
//   full   - count == 2^DEPTH_LOG2
//   empty  - count == 0
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally on their DEPTH_LOG2-bit width.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
// Buffers bytes between a CPU-side interface and a byte-wide UART core.
//   TX path: CPU pushes into a 16-entry FIFO; the TX FSM hands the head to
//            the core when core_thre=1 (core_d registered, core_wrtx strobe),
//            then holds one cycle to cover the core's thre update latency.
//   RX path: on core_dv the RX FSM captures {core_fe, core_q} into a FIFO and
//            strobes core_rd for one cycle; the following cycle ignores dv,
//            which the core only drops after seeing core_rd.
// Optional build macro:
//   UART_FIFO_FE_TAG_EN - store the framing-error tag with each RX byte and
//                         present it on rdata_fe (otherwise rdata_fe = 0).
// Ports:
//   clk, resetb                 - clock, asynchronous active-low reset
//   wdata, wr                   - CPU TX byte and push
//   rd                          - CPU pop of the RX head
//   clr_err                     - clear sticky rx_ovf / fe_err
//   rdata, rdata_fe, rx_valid   - RX head byte, its FE tag, RX not empty
//   tx_full, tx_empty           - TX FIFO status
//   tx_count, rx_count          - FIFO occupancies
//   rx_ovf, fe_err              - sticky overflow / framing-error flags
//   core_d, core_wrtx, core_thre- core TX data, write strobe, buffer empty
//   core_q, core_dv, core_fe,
//   core_ove, core_rd           - core RX data, flags and acknowledge
// ---------------------------------------------------------------------------
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic [7:0]          wdata,
  input  logic                wr,
  input  logic                rd,
  input  logic                clr_err,
  output logic [7:0]          rdata,
  output logic                rdata_fe,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                rx_valid,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic                rx_ovf,
  output logic                fe_err,
  output logic [7:0]          core_d,
  output logic                core_wrtx,
  input  logic                core_thre,
  input  logic [7:0]          core_q,
  input  logic                core_dv,
  input  logic                core_fe,
  input  logic                core_ove,
  output logic                core_rd
);

`ifdef UART_FIFO_FE_TAG_EN
  localparam int RX_W = 9;
`else
  localparam int RX_W = 8;
`endif

  tx_state_e       tx_state;
  tx_state_e       tx_state_nxt;
  rx_state_e       rx_state;
  rx_state_e       rx_state_nxt;
  logic [7:0]      tx_head;
  logic            tx_pop;
  logic [RX_W-1:0] rx_din;
  logic [RX_W-1:0] rx_head;
  logic            rx_cap;
  logic            rx_full;
  logic            rx_empty;
  logic            ovf_set;
  logic            fe_set;

  sync_fifo #(
    .DATA_W     (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (wr),
    .pop    (tx_pop),
    .din    (wdata),
    .dout   (tx_head),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  sync_fifo #(
    .DATA_W     (RX_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (rx_cap),
    .pop    (rd),
    .din    (rx_din),
    .dout   (rx_head),
    .count  (rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

`ifdef UART_FIFO_FE_TAG_EN
  assign rx_din   = {core_fe, core_q};
  assign rdata    = rx_head[7:0];
  assign rdata_fe = rx_head[8];
`else
  assign rx_din   = core_q;
  assign rdata    = rx_head;
  assign rdata_fe = 1'b0;
`endif

  assign rx_valid = ~rx_empty;

  // TX FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_nxt;
    end
  end

  // TX_HOLD is the cycle core_wrtx is high; the core's thre is not yet
  // updated then, so no new byte may be launched from it.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    core_wrtx    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && core_thre) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_HOLD;
        end
      end
      TX_HOLD: begin
        core_wrtx    = 1'b1;
        tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // core_d is reset so the core never sees stale data after a reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      core_d <= 8'h00;
    end else if (tx_pop) begin
      core_d <= tx_head;
    end
  end

  // RX FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_state_nxt;
    end
  end

  // RX_ACK drives core_rd; core_dv is still high in that cycle and is
  // deliberately ignored so a byte is captured only once.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cap       = 1'b0;
    core_rd      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (core_dv) begin
          rx_cap       = 1'b1;
          rx_state_nxt = RX_ACK;
        end
      end
      RX_ACK: begin
        core_rd      = 1'b1;
        rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign ovf_set = rx_cap & (rx_full | core_ove);
  assign fe_set  = rx_cap & core_fe;

  // Sticky flags: a set event in the clear cycle wins.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_ovf <= 1'b0;
      fe_err <= 1'b0;
    end else begin
      rx_ovf <= ovf_set | (rx_ovf & ~clr_err);
      fe_err <= fe_set  | (fe_err & ~clr_err);
    end
  end

endmodule
